// File: rtl/reg_file_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_file_wr_arbiter_if
// Bundles the two requester handshakes and the register-file write bus of
// reg_file_wr_arbiter.
//
// Signals:
//   req_a / addr_a / data_a  requester A write request, target and data
//   req_b / addr_b / data_b  requester B write request, target and data
//   ack_a / ack_b            one-cycle grant pulses back to the requesters
//   ce                       one-hot clock enables, one per register slice
//   wdata                    shared write data fed to every slice
//   init_done                high once the power-on clear has finished
//   busy                     high while clearing or issuing a write
//
// Modports:
//   master  requester / register-file side (drives requests)
//   slave   arbiter side (drives acks and the write bus)
// ---------------------------------------------------------------------------
interface reg_file_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
);

  logic             req_a;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_a;
  logic             ack_b;
  logic [NREG-1:0]  ce;
  logic [WIDTH-1:0] wdata;
  logic             init_done;
  logic             busy;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  ack_a, ack_b, ce, wdata, init_done, busy
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output ack_a, ack_b, ce, wdata, init_done, busy
  );

endinterface

// File: rtl/reg_file_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_wr_arbiter
// Write-port controller for a bank of NREG clock-enabled WIDTH-bit register
// slices. After reset it zeroes every register one per cycle, then grants
// writes from two requesters (A, B) with round-robin priority on ties.
// A granted write holds ce/wdata/ack for exactly one cycle, followed by one
// WRITE cycle during which requests are ignored.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of reg_file_wr_arbiter_if (requests in; ack_a,
//         ack_b, ce, wdata, init_done, busy out -- all registered)
//
// Optional feature:
//   REG0_ZERO_EN  when defined, register 0 is read-only zero: a granted
//                 write to address 0 is still acknowledged but its ce stays
//                 0. The clear sequence still writes register 0.
// ---------------------------------------------------------------------------
module reg_file_wr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = $clog2(NREG)
) (
  input logic                    clk,
  input logic                    rst,
  reg_file_wr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_CLR,
    ST_IDLE,
    ST_WRITE
  } state_t;

  // Last-granted marker: 0 = A, 1 = B.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_t           r_state;
  logic [AW-1:0]    r_clrPtr;
  logic             r_lastGnt;
  logic [NREG-1:0]  r_ce;
  logic [WIDTH-1:0] r_wdata;
  logic             r_ackA;
  logic             r_ackB;
  logic             r_initDone;
  logic             r_busy;

  logic             w_grantA;
  logic             w_grantB;
  logic [AW-1:0]    w_gntAddr;
  logic [WIDTH-1:0] w_gntData;
  logic [NREG-1:0]  w_gntCe;
  logic [NREG-1:0]  w_clrCe;

  // A lone requester always wins; on a tie the one that did not win last
  // time gets the grant, so neither side can be starved.
  assign w_grantA  = bus.req_a && (!bus.req_b || (r_lastGnt == GNT_B));
  assign w_grantB  = bus.req_b && (!bus.req_a || (r_lastGnt == GNT_A));
  assign w_gntAddr = w_grantA ? bus.addr_a : bus.addr_b;
  assign w_gntData = w_grantA ? bus.data_a : bus.data_b;

  assign w_clrCe   = {{(NREG-1){1'b0}}, 1'b1} << r_clrPtr;

`ifdef REG0_ZERO_EN
  // Register 0 is hard zero: suppress its enable but keep the handshake.
  assign w_gntCe   = (w_gntAddr == '0) ? '0
                                       : ({{(NREG-1){1'b0}}, 1'b1} << w_gntAddr);
`else
  assign w_gntCe   = {{(NREG-1){1'b0}}, 1'b1} << w_gntAddr;
`endif

  // Main FSM. Every output is a register updated here so the slices and the
  // requesters see glitch-free signals for a full cycle after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLR;
      r_clrPtr   <= '0;
      r_lastGnt  <= GNT_B;
      r_ce       <= '0;
      r_wdata    <= '0;
      r_ackA     <= 1'b0;
      r_ackB     <= 1'b0;
      r_initDone <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      unique case (r_state)
        ST_CLR: begin
          // One register per cycle; requests are deliberately ignored.
          r_ce     <= w_clrCe;
          r_wdata  <= '0;
          r_ackA   <= 1'b0;
          r_ackB   <= 1'b0;
          r_busy   <= 1'b1;
          r_clrPtr <= r_clrPtr + AW'(1);
          if (r_clrPtr == AW'(NREG - 1)) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          // init_done rises on the first edge taken in IDLE, which is also
          // the first edge at which a pending request can be granted.
          r_initDone <= 1'b1;
          if (w_grantA || w_grantB) begin
            r_ce      <= w_gntCe;
            r_wdata   <= w_gntData;
            r_ackA    <= w_grantA;
            r_ackB    <= w_grantB;
            r_busy    <= 1'b1;
            r_lastGnt <= w_grantA ? GNT_A : GNT_B;
            r_state   <= ST_WRITE;
          end else begin
            r_ce    <= '0;
            r_wdata <= '0;
            r_ackA  <= 1'b0;
            r_ackB  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        ST_WRITE: begin
          // The slice captured the write at this edge; withdraw everything so
          // a requester dropping req on ack is never granted twice.
          r_ce    <= '0;
          r_wdata <= '0;
          r_ackA  <= 1'b0;
          r_ackB  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_CLR;
        end
      endcase
    end
  end

  assign bus.ce        = r_ce;
  assign bus.wdata     = r_wdata;
  assign bus.ack_a     = r_ackA;
  assign bus.ack_b     = r_ackB;
  assign bus.init_done = r_initDone;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wr_arbiter
// Self-checking bench for reg_file_wr_arbiter. A small model of the eight
// register slices captures wdata on ce so final register contents can be
// checked as well as the cycle-by-cycle outputs. Honours REG0_ZERO_EN.
// ---------------------------------------------------------------------------
module tb_reg_file_wr_arbiter;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;

`ifdef REG0_ZERO_EN
  localparam logic [NREG-1:0]  REG0_CE  = 8'h00;
  localparam logic [WIDTH-1:0] REG0_VAL = 16'h0000;
`else
  localparam logic [NREG-1:0]  REG0_CE  = 8'h01;
  localparam logic [WIDTH-1:0] REG0_VAL = 16'h1234;
`endif

  typedef struct {
    logic             reqA;
    logic [AW-1:0]    addrA;
    logic [WIDTH-1:0] dataA;
    logic             reqB;
    logic [AW-1:0]    addrB;
    logic [WIDTH-1:0] dataB;
    logic             expAckA;
    logic             expAckB;
    logic [NREG-1:0]  expCe;
    logic [WIDTH-1:0] expWdata;
    logic             expBusy;
    logic             expInit;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [WIDTH-1:0] model [NREG];

  reg_file_wr_arbiter_if #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) ifc ();

  reg_file_wr_arbiter #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register slices: capture wdata on each enabled slice.
  initial begin
    for (int i = 0; i < NREG; i++) model[i] = 16'hDEAD;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (ifc.ce[i] === 1'b1) model[i] <= ifc.wdata;
    end
  end

  function automatic vec_t mk(input logic ra, input logic [AW-1:0] aa,
                              input logic [WIDTH-1:0] da, input logic rb,
                              input logic [AW-1:0] ab, input logic [WIDTH-1:0] db,
                              input logic eAckA, input logic eAckB,
                              input logic [NREG-1:0] eCe, input logic [WIDTH-1:0] eWd,
                              input logic eBusy, input logic eInit);
    vec_t v;
    v.reqA = ra;  v.addrA = aa;  v.dataA = da;
    v.reqB = rb;  v.addrB = ab;  v.dataB = db;
    v.expAckA = eAckA;  v.expAckB = eAckB;
    v.expCe = eCe;  v.expWdata = eWd;
    v.expBusy = eBusy;  v.expInit = eInit;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifc.req_a  = v.reqA;
    ifc.addr_a = v.addrA;
    ifc.data_a = v.dataA;
    ifc.req_b  = v.reqB;
    ifc.addr_b = v.addrB;
    ifc.data_b = v.dataB;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    cmp({tag, ".ack_a"},     {15'd0, ifc.ack_a},     {15'd0, v.expAckA});
    cmp({tag, ".ack_b"},     {15'd0, ifc.ack_b},     {15'd0, v.expAckB});
    cmp({tag, ".ce"},        {8'd0, ifc.ce},         {8'd0, v.expCe});
    cmp({tag, ".wdata"},     ifc.wdata,              v.expWdata);
    cmp({tag, ".busy"},      {15'd0, ifc.busy},      {15'd0, v.expBusy});
    cmp({tag, ".init_done"}, {15'd0, ifc.init_done}, {15'd0, v.expInit});
    cmp({tag, ".ack_excl"},  {15'd0, ifc.ack_a & ifc.ack_b}, 16'd0);
    cmp({tag, ".ce_onehot0"}, {15'd0, $onehot0(ifc.ce)}, 16'd1);
  endtask

  // Drive inputs, let one rising edge pass, check on the falling edge.
  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge clk);
    @(negedge clk);
    checkOutput(v, tag);
  endtask

  task automatic checkResetValues(input string tag);
    cmp({tag, ".ce"},        {8'd0, ifc.ce},         16'd0);
    cmp({tag, ".wdata"},     ifc.wdata,              16'd0);
    cmp({tag, ".ack_a"},     {15'd0, ifc.ack_a},     16'd0);
    cmp({tag, ".ack_b"},     {15'd0, ifc.ack_b},     16'd0);
    cmp({tag, ".init_done"}, {15'd0, ifc.init_done}, 16'd0);
    cmp({tag, ".busy"},      {15'd0, ifc.busy},      16'd1);
  endtask

  // Called on a falling edge; leaves reset released on the next falling edge.
  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    checkResetValues(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [16];
  vec_t v;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Table: clear with B waiting, B granted first, then A writes.
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(0, 0, 16'h0, 1, 3'd5, 16'hBEEF, 0, 0, 8'(1 << i), 16'h0, 1, 0);
    vecs[8]  = mk(0, 0, 16'h0, 1, 3'd5, 16'hBEEF, 0, 1, 8'h20, 16'hBEEF, 1, 1);
    vecs[9]  = mk(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 8'h00, 16'h0, 0, 1);
    vecs[10] = mk(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 8'h00, 16'h0, 0, 1);
    vecs[11] = mk(1, 3'd3, 16'h00A5, 0, 0, 16'h0, 1, 0, 8'h08, 16'h00A5, 1, 1);
    vecs[12] = mk(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 8'h00, 16'h0, 0, 1);
    vecs[13] = mk(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 8'h00, 16'h0, 0, 1);
    vecs[14] = mk(1, 3'd0, 16'h1234, 0, 0, 16'h0, 1, 0, REG0_CE, 16'h1234, 1, 1);
    vecs[15] = mk(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 8'h00, 16'h0, 0, 1);

    #2;
    checkResetValues("reset0");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    cmp("model.r0", model[0], REG0_VAL);
    cmp("model.r3", model[3], 16'h00A5);
    cmp("model.r5", model[5], 16'hBEEF);
    cmp("model.r7", model[7], 16'h0000);

    // Mid-clear reset at clr_ptr=5, then clear restarts from register 0;
    // both requesters held throughout to exercise the tie alternation.
    doReset("rstA");
    for (int k = 0; k < 5; k++)
      runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'(1 << k), 16'h0, 1, 0),
             $sformatf("clrA%0d", k));
    rst = 1'b1;
    #1;
    checkResetValues("midClrRst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++)
      runVec(mk(1, 3'd1, 16'h0A0A, 1, 3'd2, 16'h0B0B, 0, 0, 8'(1 << k), 16'h0, 1, 0),
             $sformatf("clrB%0d", k));
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1)
        v = mk(1, 3'd1, 16'h0A0A, 1, 3'd2, 16'h0B0B, 0, 0, 8'h00, 16'h0, 0, 1);
      else if ((k / 2) % 2 == 0)
        v = mk(1, 3'd1, 16'h0A0A, 1, 3'd2, 16'h0B0B, 1, 0, 8'h02, 16'h0A0A, 1, 1);
      else
        v = mk(1, 3'd1, 16'h0A0A, 1, 3'd2, 16'h0B0B, 0, 1, 8'h04, 16'h0B0B, 1, 1);
      runVec(v, $sformatf("tie%0d", k));
    end

    // Same target from both sides: serialized, B's later write survives.
    doReset("rstC");
    for (int k = 0; k < 8; k++)
      runVec(mk(1, 3'd4, 16'h1111, 1, 3'd4, 16'h2222, 0, 0, 8'(1 << k), 16'h0, 1, 0),
             $sformatf("clrC%0d", k));
    runVec(mk(1, 3'd4, 16'h1111, 1, 3'd4, 16'h2222, 1, 0, 8'h10, 16'h1111, 1, 1), "sameA");
    runVec(mk(0, 3'd0, 16'h0,    1, 3'd4, 16'h2222, 0, 0, 8'h00, 16'h0,    0, 1), "sameW1");
    runVec(mk(0, 3'd0, 16'h0,    1, 3'd4, 16'h2222, 0, 1, 8'h10, 16'h2222, 1, 1), "sameB");
    runVec(mk(0, 3'd0, 16'h0,    0, 3'd0, 16'h0,    0, 0, 8'h00, 16'h0,    0, 1), "sameW2");
    cmp("model.r4", model[4], 16'h2222);
    cmp("model.r2", model[2], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
